// File: rtl/vec_mul_pkg.sv
// Shared sizing helpers for the vec_mul dot-product engine.
// Widths, latency and flat-bus offsets of the adder tree.
package vec_mul_pkg;

    function automatic int f_pad(input int c);
        return 2 ** $clog2(c);
    endfunction

    function automatic int f_lat(input int c);
        return $clog2(c) + 1;
    endfunction

    function automatic int f_wy(input int wx, input int wk, input int c);
        return wx + wk + $clog2(c);
    endfunction

    // Bit offset of tree level lvl in the flat bus; level 0 holds products.
    function automatic int f_off(input int p, input int wp, input int lvl);
        int o;
        o = 0;
        for (int j = 0; j < lvl; j++) begin
            o += (p >> j) * (wp + j);
        end
        return o;
    endfunction

endpackage

// File: rtl/vec_add_stage.sv
// One registered level of the signed adder tree:
// N lanes of W bits summed pairwise into N/2 lanes of W+1 bits.
module vec_add_stage #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic [N*W-1:0]           din_i,
    output logic [(N/2)*(W+1)-1:0]   dout_o
);

    logic [(N/2)*(W+1)-1:0] sum_d;
    logic [(N/2)*(W+1)-1:0] sum_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N / 2; i++) begin
            sum_d[i*(W+1) +: (W+1)] =
                (W+1)'($signed(din_i[(2*i)*W +: W])) +
                (W+1)'($signed(din_i[(2*i+1)*W +: W]));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sum_q <= '0;
        end else if (enable) begin
            sum_q <= sum_d;
        end
    end

    assign dout_o = sum_q;

endmodule

// File: rtl/vec_mul.sv
// Pipelined signed dot product: one multiply stage feeding a
// registered binary adder tree, plus a matching valid shift register.
module vec_mul
    import vec_mul_pkg::*;
#(
    parameter  int C       = 4,
    parameter  int W_X     = 8,
    parameter  int W_K     = 8,
    localparam int W_Y     = f_wy(W_X, W_K, C),
    localparam int LATENCY = f_lat(C)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             enable,
    input  logic [C*W_X-1:0] x,
    input  logic [C*W_K-1:0] k,
    output logic [W_Y-1:0]   y_out,
    output logic             v_valid
);

    localparam int P     = f_pad(C);
    localparam int LOG   = $clog2(C);
    localparam int WP    = W_X + W_K;
    localparam int BUS_W = f_off(P, WP, LOG + 1);

    logic [BUS_W-1:0]   bus;
    logic [P*WP-1:0]    p_d;
    logic [P*WP-1:0]    p_q;
    logic [LATENCY-1:0] vld_q;

    // Lanes C..P-1 stay zero so the tree can be a full power of two.
    always_comb begin
        p_d = '0;
        for (int c = 0; c < C; c++) begin
            p_d[c*WP +: WP] = WP'($signed(x[c*W_X +: W_X])) *
                              WP'($signed(k[c*W_K +: W_K]));
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            p_q <= '0;
        end else if (enable) begin
            p_q <= p_d;
        end
    end

    assign bus[0 +: P*WP] = p_q;

    for (genvar l = 0; l < LOG; l++) begin : g_lvl
        localparam int N  = P >> l;
        localparam int W  = WP + l;
        localparam int IO = f_off(P, WP, l);
        localparam int OO = f_off(P, WP, l + 1);

        vec_add_stage #(
            .N (N),
            .W (W)
        ) u_add (
            .clk    (clk),
            .rstn   (rstn),
            .enable (enable),
            .din_i  (bus[IO +: N*W]),
            .dout_o (bus[OO +: (N/2)*(W+1)])
        );
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_q <= '0;
        end else if (enable) begin
            vld_q <= {vld_q[LATENCY-2:0], 1'b1};
        end
    end

    assign y_out   = bus[f_off(P, WP, LOG) +: W_Y];
    assign v_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_vec_mul.sv
// Directed plus random bench for vec_mul against a history-based
// dot-product model (result of the sample taken LATENCY enabled edges ago).
module tb_vec_mul;

    localparam int C   = 4;
    localparam int WX  = 8;
    localparam int WK  = 8;
    localparam int WY  = WX + WK + $clog2(C);
    localparam int LAT = $clog2(C) + 1;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            enable = 1'b0;
    logic [C*WX-1:0] x = '0;
    logic [C*WK-1:0] k = '0;
    logic [WY-1:0]   y_out;
    logic            v_valid;

    int checks = 0;
    int errors = 0;
    int hist[$];
    int exp_y = 0;
    logic exp_v = 1'b0;

    vec_mul #(.C(C), .W_X(WX), .W_K(WK)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (enable),
        .x       (x),
        .k       (k),
        .y_out   (y_out),
        .v_valid (v_valid)
    );

    always #5 clk = ~clk;

    function automatic int dot();
        int s;
        int xi;
        int ki;
        s = 0;
        for (int c = 0; c < C; c++) begin
            xi = $signed(x[c*WX +: WX]);
            ki = $signed(k[c*WK +: WK]);
            s += xi * ki;
        end
        return s;
    endfunction

    task automatic chk_y(input string tag, input int expv);
        logic [WY-1:0] e;
        e = WY'(expv);
        checks++;
        assert (y_out === e) else begin
            errors++;
            $error("FAIL %s: y_out=%0d expected=%0d", tag,
                   $signed(y_out), $signed(e));
        end
    endtask

    task automatic chk_v(input string tag, input logic expv);
        checks++;
        assert (v_valid === expv) else begin
            errors++;
            $error("FAIL %s: v_valid=%b expected=%b", tag, v_valid, expv);
        end
    endtask

    // One clock edge; update the model from what was sampled, then compare.
    task automatic tick();
        int n;
        @(posedge clk);
        #1;
        if (!rstn) begin
            hist.delete();
            exp_y = 0;
            exp_v = 1'b0;
        end else if (enable) begin
            hist.push_back(dot());
            n = hist.size();
            if (n >= LAT) begin
                exp_y = hist[n-LAT];
                exp_v = 1'b1;
            end
        end
        chk_y("model_y", exp_y);
        chk_v("model_v", exp_v);
    endtask

    task automatic set_lanes(input int x3, input int x2, input int x1,
                             input int x0, input int k3, input int k2,
                             input int k1, input int k0);
        x = {WX'(x3), WX'(x2), WX'(x1), WX'(x0)};
        k = {WK'(k3), WK'(k2), WK'(k1), WK'(k0)};
    endtask

    task automatic randomize_in();
        x = $urandom();
        k = $urandom();
    endtask

    initial begin
        int d0;

        // Reset has priority over enable with live inputs.
        enable = 1'b1;
        x = 32'h7f81_55aa;
        k = 32'h8033_c07f;
        rstn = 1'b0;
        tick();
        tick();
        chk_y("rst_prio_y", 0);
        chk_v("rst_prio_v", 1'b0);

        rstn = 1'b1;
        x = 32'h0302_0108;
        k = 32'h0103_0309;
        tick();
        tick();
        chk_v("t1_v_early", 1'b0);
        tick();
        chk_y("t1_y", 84);
        chk_v("t1_v", 1'b1);
        enable = 1'b0;
        randomize_in();
        for (int i = 0; i < 10; i++) tick();
        chk_y("t1_hold_y", 84);
        chk_v("t1_hold_v", 1'b1);

        enable = 1'b1;
        set_lanes(-128, -128, -128, -128, -128, -128, -128, -128);
        repeat (LAT) tick();
        chk_y("max_pos", 65536);
        set_lanes(-128, -128, -128, -128, 127, 127, 127, 127);
        repeat (LAT) tick();
        chk_y("max_neg", -65024);
        set_lanes(-1, 2, -3, 4, 5, -6, 7, -8);
        repeat (LAT) tick();
        chk_y("mixed", -70);

        // Streaming with a 2-cycle stall in the middle.
        for (int i = 0; i < 8; i++) begin
            enable = 1'b1;
            randomize_in();
            tick();
            if (i == 3) begin
                enable = 1'b0;
                randomize_in();
                tick();
                tick();
            end
        end
        enable = 1'b1;
        randomize_in();
        repeat (LAT) tick();

        // Reset mid-pipeline, then refill with a stall during fill.
        randomize_in();
        tick();
        randomize_in();
        tick();
        rstn = 1'b0;
        tick();
        chk_y("midrst_y", 0);
        chk_v("midrst_v", 1'b0);
        rstn = 1'b1;
        set_lanes(1, -2, 3, -4, 10, 20, -30, 40);
        d0 = dot();
        tick();
        randomize_in();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        chk_v("refill_v_early", 1'b0);
        randomize_in();
        tick();
        chk_v("refill_v", 1'b1);
        chk_y("refill_first", d0);

        // Random enables and occasional resets.
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 3) != 0);
            rstn = ($urandom_range(0, 50) != 0);
            randomize_in();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
